// File: rtl/spi_frame_tx.sv
// Mode-0 SPI serializer for the display path: shifts a latched byte frame out
// MSB-byte-first, with a fixed idle gap between bytes and a completion pulse.
module spi_frame_tx #(
  parameter int FRAME_BYTES  = 19,
  parameter int CLK_DIV      = 50,
  parameter int BYTE_GAP     = 100,
  parameter int STOP_AT_NULL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     begin_transmission,
  input  logic [8*FRAME_BYTES-1:0] data_in,
  output logic                     ss,
  output logic                     sclk,
  output logic                     mosi,
  output logic                     busy,
  output logic                     end_transmission,
  output logic [1:0]               state_dbg
);

  localparam int W     = 8 * FRAME_BYTES;
  localparam int BC_W  = $clog2(FRAME_BYTES + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(BYTE_GAP - 1);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state, state_d;
  logic [W-1:0]     shreg, shreg_d;
  logic [7:0]       sent_byte, sent_byte_d;
  logic [7:0]       cur_byte;
  logic [BC_W-1:0]  byte_cnt, byte_cnt_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt, div_cnt_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic             ss_d, sclk_d, mosi_d, busy_d, end_d;
  logic             armed, armed_d;

  // Handshake: begin_transmission is a level request, accepted in IDLE only
  // when armed; armed clears on accept and re-sets on any cycle the request
  // is low, so a request held high across completion never restarts a frame.

  // Bits leave the MSB of shreg; cur_byte is the byte whose last bit is on mosi.
  assign cur_byte  = {sent_byte[6:0], mosi};
  assign state_dbg = state;

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    sent_byte_d = sent_byte;
    byte_cnt_d  = byte_cnt;
    bit_cnt_d   = bit_cnt;
    div_cnt_d   = div_cnt;
    gap_cnt_d   = gap_cnt;
    ss_d        = ss;
    sclk_d      = sclk;
    mosi_d      = mosi;
    busy_d      = busy;
    end_d       = 1'b0;
    armed_d     = armed | ~begin_transmission;

    case (state)
      IDLE: begin
        if (begin_transmission && armed) begin
          shreg_d    = data_in;
          ss_d       = 1'b0;
          sclk_d     = 1'b0;
          busy_d     = 1'b1;
          mosi_d     = data_in[W-1];
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          armed_d    = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk;
          if (sclk) begin
            sent_byte_d = cur_byte;
            if (bit_cnt != 3'd7) begin
              bit_cnt_d = bit_cnt + 3'd1;
              shreg_d   = shreg << 1;
              mosi_d    = shreg[W-2];
            end else if (byte_cnt == LAST_BYTE ||
                         (STOP_AT_NULL != 0 && cur_byte == 8'h00)) begin
              state_d = DONE;
            end else begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end
          end
        end else begin
          div_cnt_d = div_cnt + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          byte_cnt_d = byte_cnt + BC_W'(1);
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          shreg_d    = shreg << 1;
          mosi_d     = shreg[W-2];
          state_d    = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt + GAP_W'(1);
        end
      end

      DONE: begin
        ss_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        end_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      shreg            <= '0;
      sent_byte        <= '0;
      byte_cnt         <= '0;
      bit_cnt          <= '0;
      div_cnt          <= '0;
      gap_cnt          <= '0;
      ss               <= 1'b1;
      sclk             <= 1'b0;
      mosi             <= 1'b0;
      busy             <= 1'b0;
      end_transmission <= 1'b0;
      armed            <= 1'b1;
    end else begin
      state            <= state_d;
      shreg            <= shreg_d;
      sent_byte        <= sent_byte_d;
      byte_cnt         <= byte_cnt_d;
      bit_cnt          <= bit_cnt_d;
      div_cnt          <= div_cnt_d;
      gap_cnt          <= gap_cnt_d;
      ss               <= ss_d;
      sclk             <= sclk_d;
      mosi             <= mosi_d;
      busy             <= busy_d;
      end_transmission <= end_d;
      armed            <= armed_d;
    end
  end

endmodule
